coin_acceptor: RTL

Front-end coin qualification stage that sits directly upstream of the vending machine top level. It synchronises and debounces the raw Rs5 and Rs10 coin-sensor levels, rejects glitches, simultaneous and inhibited coins, and detects jams. For each good coin it emits exactly one single-cycle rs_5_in or rs_10_in pulse, which drives the item FSMs' coin inputs.

---
 rtl/coin_acceptor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// Coin qualification front end: synchronises and debounces the Rs5/Rs10 sensors and
// emits one registered pulse per good coin, rejecting glitches, double and inhibited coins.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 3,
  parameter int JAM_CYCLES      = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic coin_5_raw,
  input  logic coin_10_raw,
  input  logic inhibit,
  output logic rs_5_in,
  output logic rs_10_in,
  output logic coin_reject,
  output logic jam,
  output logic busy
);

  localparam int MAX_DL = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_P  = (MAX_DL > JAM_CYCLES) ? MAX_DL : JAM_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] JAM_LIMIT = CW'(JAM_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    EMIT,
    WAIT_RELEASE,
    LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync5_q, sync5_d;
  logic [1:0]    sync10_q, sync10_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] jcnt_q, jcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          seen5_q, seen5_d;
  logic          seen10_q, seen10_d;
  logic          rs5_q, rs5_d;
  logic          rs10_q, rs10_d;
  logic          rej_q, rej_d;
  logic          jam_q, jam_d;
  logic          busy_q, busy_d;

  logic          s5, s10, lvl;
  logic          acc5, acc10;
  logic [CW-1:0] jcnt_next;

  always_comb begin
    s5        = sync5_q[1];
    s10       = sync10_q[1];
    lvl       = s5 | s10;
    acc5      = seen5_q | s5;
    acc10     = seen10_q | s10;
    jcnt_next = (jcnt_q == JAM_LIMIT) ? JAM_LIMIT : jcnt_q + ONE;

    sync5_d   = {sync5_q[0], coin_5_raw};
    sync10_d  = {sync10_q[0], coin_10_raw};
    state_d   = state_q;
    cnt_d     = cnt_q;
    jcnt_d    = jcnt_q;
    lcnt_d    = lcnt_q;
    seen5_d   = seen5_q;
    seen10_d  = seen10_q;
    rs5_d     = 1'b0;
    rs10_d    = 1'b0;
    rej_d     = 1'b0;
    jam_d     = jam_q;

    case (state_q)
      IDLE: begin
        if (lvl) begin
          state_d  = QUALIFY;
          cnt_d    = ONE;
          seen5_d  = s5;
          seen10_d = s10;
        end
      end

      QUALIFY: begin
        if (!lvl) begin
          state_d  = IDLE;
          cnt_d    = '0;
          seen5_d  = 1'b0;
          seen10_d = 1'b0;
        end else begin
          seen5_d  = acc5;
          seen10_d = acc10;
          if (cnt_q == DEB_LAST) begin
            // Outputs are registered, so the verdict is decided on the edge entering EMIT.
            state_d = EMIT;
            if ((acc5 && acc10) || inhibit) begin
              rej_d = 1'b1;
            end else begin
              rs5_d  = acc5;
              rs10_d = acc10;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      EMIT: begin
        state_d  = WAIT_RELEASE;
        jcnt_d   = '0;
        cnt_d    = '0;
        seen5_d  = 1'b0;
        seen10_d = 1'b0;
      end

      WAIT_RELEASE: begin
        if (!lvl) begin
          state_d = LOCKOUT;
          lcnt_d  = '0;
          jam_d   = 1'b0;
        end else begin
          jcnt_d = jcnt_next;
          jam_d  = jam_q | (jcnt_next == JAM_LIMIT);
        end
      end

      LOCKOUT: begin
        if (lcnt_q == LOCK_LAST) begin
          state_d = IDLE;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      sync5_q  <= '0;
      sync10_q <= '0;
      cnt_q    <= '0;
      jcnt_q   <= '0;
      lcnt_q   <= '0;
      seen5_q  <= 1'b0;
      seen10_q <= 1'b0;
      rs5_q    <= 1'b0;
      rs10_q   <= 1'b0;
      rej_q    <= 1'b0;
      jam_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync5_q  <= sync5_d;
      sync10_q <= sync10_d;
      cnt_q    <= cnt_d;
      jcnt_q   <= jcnt_d;
      lcnt_q   <= lcnt_d;
      seen5_q  <= seen5_d;
      seen10_q <= seen10_d;
      rs5_q    <= rs5_d;
      rs10_q   <= rs10_d;
      rej_q    <= rej_d;
      jam_q    <= jam_d;
      busy_q   <= busy_d;
    end
  end

  assign rs_5_in     = rs5_q;
  assign rs_10_in    = rs10_q;
  assign coin_reject = rej_q;
  assign jam         = jam_q;
  assign busy        = busy_q;

endmodule
